// File: rtl/ni_pkg.sv
// Shared definitions for the noninterference miter: counter width default and
// lane extraction used to split the packed channel buses.
package ni_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int MAX_W     = 64;
    localparam int MAX_BUS   = 1024;

    // Returns lane c of a bus of w-wide lanes, zero-extended to MAX_W bits.
    function automatic logic [MAX_W-1:0] ch_slice(input logic [MAX_BUS-1:0] bus,
                                                  input int c,
                                                  input int w);
        logic [MAX_BUS-1:0] shifted;
        logic [MAX_W-1:0]   mask;
        shifted = bus >> (c * w);
        mask    = (MAX_W'(1) << w) - MAX_W'(1);
        return shifted[MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/ni_copy_pipe.sv
// One channel of one copy: a DEPTH-stage {public, secret} shift pipeline whose
// observable is the bitwise AND of the last stage's public and secret words.
module ni_copy_pipe
    import ni_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] pub_i,
    input  logic [WIDTH-1:0] sec_i,
    output logic [WIDTH-1:0] obs_o
);

    typedef struct packed {
        logic [WIDTH-1:0] pub;
        logic [WIDTH-1:0] sec;
    } stage_t;

    stage_t stage_q [DEPTH];
    stage_t stage_d [DEPTH];

    // Flush beats in_valid; an idle cycle injects a zero bubble.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            stage_d[k] = '0;
        end
        if (!flush) begin
            if (in_valid) begin
                stage_d[0].pub = pub_i;
                stage_d[0].sec = sec_i;
            end
            for (int k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign obs_o = stage_q[DEPTH-1].pub & stage_q[DEPTH-1].sec;

endmodule

// File: rtl/ni_miter_pipe.sv
// Noninterference miter: two copies of an N_CH-channel pipeline share the public
// stream; any observable divergence before declassification raises a sticky alarm.
module ni_miter_pipe
    import ni_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 2,
    parameter int N_CH        = 2,
    parameter int STICKY_DECL = 1,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [N_CH*WIDTH-1:0] pub_in,
    input  logic [N_CH*WIDTH-1:0] sec_a,
    input  logic [N_CH*WIDTH-1:0] sec_b,
    input  logic                  declassify,
    output logic                  mismatch,
    output logic [N_CH-1:0]       mismatch_ch,
    output logic                  alarm,
    output logic                  window_open,
    output logic [CNT_W-1:0]      first_cyc
);

    logic             decl_q,      decl_d;
    logic             alarm_q,     alarm_d;
    logic [CNT_W-1:0] first_cyc_q, first_cyc_d;
    logic [CNT_W-1:0] cyc_cnt_q,   cyc_cnt_d;
    logic             suppressed;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [WIDTH-1:0] pub_c;
        logic [WIDTH-1:0] sec_a_c;
        logic [WIDTH-1:0] sec_b_c;
        logic [WIDTH-1:0] obs_a;
        logic [WIDTH-1:0] obs_b;

        assign pub_c   = WIDTH'(ch_slice(MAX_BUS'(pub_in), c, WIDTH));
        assign sec_a_c = WIDTH'(ch_slice(MAX_BUS'(sec_a),  c, WIDTH));
        assign sec_b_c = WIDTH'(ch_slice(MAX_BUS'(sec_b),  c, WIDTH));

        // Each copy keeps its own public stages; they are identical and may be merged.
        ni_copy_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_copy_a (
            .clock    (clock),
            .reset_n  (reset_n),
            .flush    (flush),
            .in_valid (in_valid),
            .pub_i    (pub_c),
            .sec_i    (sec_a_c),
            .obs_o    (obs_a)
        );

        ni_copy_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_copy_b (
            .clock    (clock),
            .reset_n  (reset_n),
            .flush    (flush),
            .in_valid (in_valid),
            .pub_i    (pub_c),
            .sec_i    (sec_b_c),
            .obs_o    (obs_b)
        );

        assign mismatch_ch[c] = (obs_a != obs_b);
    end

    // Same-cycle declassify closes the window at once; the latch only matters when sticky.
    always_comb begin
        suppressed  = declassify | ((STICKY_DECL != 0) & decl_q);
        window_open = ~suppressed;
        mismatch    = (|mismatch_ch) & ~suppressed;
        decl_d      = decl_q | declassify;
        alarm_d     = alarm_q | mismatch;
        first_cyc_d = (mismatch & ~alarm_q) ? cyc_cnt_q : first_cyc_q;
        cyc_cnt_d   = (cyc_cnt_q == '1) ? cyc_cnt_q : cyc_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            decl_q      <= 1'b0;
            alarm_q     <= 1'b0;
            first_cyc_q <= '0;
            cyc_cnt_q   <= '0;
        end else begin
            decl_q      <= decl_d;
            alarm_q     <= alarm_d;
            first_cyc_q <= first_cyc_d;
            cyc_cnt_q   <= cyc_cnt_d;
        end
    end

    assign alarm     = alarm_q;
    assign first_cyc = first_cyc_q;

endmodule

// File: tb/tb_ni_miter_pipe.sv
// Directed bench for ni_miter_pipe: sticky, non-sticky and narrow-counter
// instances share one stimulus stream; expectations are hand-computed.
module tb_ni_miter_pipe;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b1;
    logic        flush, inValid, declassify;
    logic [15:0] pubIn, secA, secB;

    logic        mm0, al0, win0;
    logic [1:0]  mmCh0;
    logic [15:0] first0;
    logic        mm1, al1, win1;
    logic [1:0]  mmCh1;
    logic [15:0] first1;
    logic        mm2, al2, win2;
    logic [1:0]  mmCh2;
    logic [3:0]  first2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clock = ~clock;

    ni_miter_pipe #(.WIDTH(8), .DEPTH(2), .N_CH(2), .STICKY_DECL(1), .CNT_W(16)) dutSticky (
        .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(inValid),
        .pub_in(pubIn), .sec_a(secA), .sec_b(secB), .declassify(declassify),
        .mismatch(mm0), .mismatch_ch(mmCh0), .alarm(al0), .window_open(win0), .first_cyc(first0)
    );

    ni_miter_pipe #(.WIDTH(8), .DEPTH(2), .N_CH(2), .STICKY_DECL(0), .CNT_W(16)) dutNonSticky (
        .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(inValid),
        .pub_in(pubIn), .sec_a(secA), .sec_b(secB), .declassify(declassify),
        .mismatch(mm1), .mismatch_ch(mmCh1), .alarm(al1), .window_open(win1), .first_cyc(first1)
    );

    ni_miter_pipe #(.WIDTH(8), .DEPTH(2), .N_CH(2), .STICKY_DECL(1), .CNT_W(4)) dutNarrow (
        .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(inValid),
        .pub_in(pubIn), .sec_a(secA), .sec_b(secB), .declassify(declassify),
        .mismatch(mm2), .mismatch_ch(mmCh2), .alarm(al2), .window_open(win2), .first_cyc(first2)
    );

    typedef struct {
        int          scen;
        int          cyc;
        bit          fl;
        bit          iv;
        bit          dc;
        logic [15:0] pub;
        logic [15:0] sa;
        logic [15:0] sb;
        bit          mm;
        logic [1:0]  ch;
        bit          al;
        bit          win;
        logic [15:0] first;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(int scen, int cy, bit fl, bit iv, bit dc,
                                   logic [15:0] pub, logic [15:0] sa, logic [15:0] sb,
                                   bit mm, logic [1:0] ch, bit al, bit win, logic [15:0] first);
        vec_t v;
        v.scen = scen; v.cyc = cy; v.fl = fl; v.iv = iv; v.dc = dc;
        v.pub = pub; v.sa = sa; v.sb = sb;
        v.mm = mm; v.ch = ch; v.al = al; v.win = win; v.first = first;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input bit fl, input bit iv, input bit dc,
                                 input logic [15:0] p, input logic [15:0] a, input logic [15:0] b);
        flush = fl; inValid = iv; declassify = dc;
        pubIn = p; secA = a; secB = b;
    endtask

    task automatic applyReset();
        reset_n = 1'b0;
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 16'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
        cyc++;
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic runTo(input int target);
        while (cyc < target) nextCycle();
    endtask

    initial begin
        int curScen;
        $display("[TB] start");
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 16'h0);

        // scen 1: ch0 divergence at cycle 5 -> mismatch at 7, alarm from 8, flush leaves alarm
        addVec(1, 0, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,2'b00,0,1,16'd0);
        addVec(1, 5, 0,1,0, 16'h00FF,16'h000F,16'h0000, 0,2'b00,0,1,16'd0);
        addVec(1, 6, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,2'b00,0,1,16'd0);
        addVec(1, 7, 0,0,0, 16'h0000,16'h0000,16'h0000, 1,2'b01,0,1,16'd0);
        addVec(1, 8, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,2'b00,1,1,16'd7);
        addVec(1, 9, 1,0,0, 16'h0000,16'h0000,16'h0000, 0,2'b00,1,1,16'd7);
        addVec(1,10, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,2'b00,1,1,16'd7);
        // scen 2: public mask of zero hides the secret
        addVec(2, 5, 0,1,0, 16'h0000,16'h000F,16'h0000, 0,2'b00,0,1,16'd0);
        addVec(2, 7, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,2'b00,0,1,16'd0);
        addVec(2, 8, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,2'b00,0,1,16'd0);
        // scen 3: declassify at 3 then divergence -> raw diff visible, no alarm
        addVec(3, 3, 0,0,1, 16'h0000,16'h0000,16'h0000, 0,2'b00,0,0,16'd0);
        addVec(3, 4, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,2'b00,0,0,16'd0);
        addVec(3, 5, 0,1,0, 16'h00FF,16'h000F,16'h0000, 0,2'b00,0,0,16'd0);
        addVec(3, 7, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,2'b01,0,0,16'd0);
        addVec(3, 8, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,2'b00,0,0,16'd0);
        // scen 4: flush at 6 (with in_valid) clears both stages
        addVec(4, 5, 0,1,0, 16'h00FF,16'h000F,16'h0000, 0,2'b00,0,1,16'd0);
        addVec(4, 6, 1,1,0, 16'h00FF,16'h000F,16'h0000, 0,2'b00,0,1,16'd0);
        addVec(4, 7, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,2'b00,0,1,16'd0);
        addVec(4, 8, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,2'b00,0,1,16'd0);
        addVec(4, 9, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,2'b00,0,1,16'd0);
        // scen 5: mismatch and declassify in the same cycle
        addVec(5, 5, 0,1,0, 16'h00FF,16'h000F,16'h0000, 0,2'b00,0,1,16'd0);
        addVec(5, 7, 0,0,1, 16'h0000,16'h0000,16'h0000, 0,2'b01,0,0,16'd0);
        addVec(5, 8, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,2'b00,0,0,16'd0);
        // scen 6: ch1 diverges (0xA5&0x3C=0x24 vs 0xA5&0x04=0x04), ch0 secrets equal
        addVec(6, 2, 0,1,0, 16'hA5FF,16'h3C11,16'h0411, 0,2'b00,0,1,16'd0);
        addVec(6, 4, 0,0,0, 16'h0000,16'h0000,16'h0000, 1,2'b10,0,1,16'd0);
        addVec(6, 5, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,2'b00,1,1,16'd4);

        curScen = -1;
        foreach (vecs[i]) begin
            if (vecs[i].scen != curScen) begin
                applyReset();
                curScen = vecs[i].scen;
            end
            runTo(vecs[i].cyc);
            applyStimulus(vecs[i].fl, vecs[i].iv, vecs[i].dc, vecs[i].pub, vecs[i].sa, vecs[i].sb);
            #1;
            checkOutput($sformatf("s%0d mismatch", curScen),    32'(mm0),    32'(vecs[i].mm));
            checkOutput($sformatf("s%0d mismatch_ch", curScen), 32'(mmCh0),  32'(vecs[i].ch));
            checkOutput($sformatf("s%0d alarm", curScen),       32'(al0),    32'(vecs[i].al));
            checkOutput($sformatf("s%0d window_open", curScen), 32'(win0),   32'(vecs[i].win));
            checkOutput($sformatf("s%0d first_cyc", curScen),   32'(first0), 32'(vecs[i].first));
        end

        // equal secrets, random public stream: never a difference
        applyReset();
        for (int n = 0; n < 200; n++) begin
            nextCycle();
            inValid = 1'($urandom);
            pubIn   = 16'($urandom);
            secA    = 16'($urandom);
            secB    = secA;
            #1;
            checkOutput("rand mismatch_ch", 32'(mmCh0), 32'(0));
            checkOutput("rand alarm",       32'(al0),   32'(0));
        end

        // reset mid-window clears everything and restarts the counter
        applyReset();
        runTo(5);
        applyStimulus(0, 1, 0, 16'h00FF, 16'h000F, 16'h0000);
        nextCycle();
        applyStimulus(0, 1, 0, 16'h00FF, 16'h000F, 16'h0000);
        runTo(8);
        #1;
        checkOutput("pre-reset alarm",       32'(al0),    32'(1));
        checkOutput("pre-reset first_cyc",   32'(first0), 32'(7));
        checkOutput("pre-reset mismatch_ch", 32'(mmCh0),  32'(1));
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid-reset alarm",       32'(al0),    32'(0));
        checkOutput("mid-reset first_cyc",   32'(first0), 32'(0));
        checkOutput("mid-reset mismatch_ch", 32'(mmCh0),  32'(0));
        checkOutput("mid-reset window_open", 32'(win0),   32'(1));
        applyReset();
        runTo(2);
        applyStimulus(0, 1, 0, 16'h00FF, 16'h000F, 16'h0000);
        runTo(4);
        #1;
        checkOutput("post-reset mismatch", 32'(mm0), 32'(1));
        runTo(5);
        #1;
        checkOutput("post-reset alarm",     32'(al0),    32'(1));
        checkOutput("post-reset first_cyc", 32'(first0), 32'(4));

        // non-sticky declassify only covers its own cycle
        applyReset();
        runTo(1);
        applyStimulus(0, 0, 1, 16'h0, 16'h0, 16'h0);
        #1;
        checkOutput("decl sticky window",    32'(win0), 32'(0));
        checkOutput("decl nonsticky window", 32'(win1), 32'(0));
        runTo(2);
        applyStimulus(0, 1, 0, 16'h00FF, 16'h000F, 16'h0000);
        #1;
        checkOutput("after decl sticky window",    32'(win0), 32'(0));
        checkOutput("after decl nonsticky window", 32'(win1), 32'(1));
        runTo(4);
        #1;
        checkOutput("nonsticky mismatch",    32'(mm1),   32'(1));
        checkOutput("nonsticky mismatch_ch", 32'(mmCh1), 32'(1));
        checkOutput("sticky mismatch",       32'(mm0),   32'(0));
        runTo(5);
        #1;
        checkOutput("nonsticky alarm",     32'(al1),    32'(1));
        checkOutput("nonsticky first_cyc", 32'(first1), 32'(4));
        checkOutput("sticky alarm",        32'(al0),    32'(0));

        // 4-bit counter saturates at 15 before the first alarm
        applyReset();
        runTo(17);
        applyStimulus(0, 1, 0, 16'h00FF, 16'h000F, 16'h0000);
        runTo(19);
        #1;
        checkOutput("narrow mismatch", 32'(mm2), 32'(1));
        runTo(20);
        #1;
        checkOutput("wide first_cyc",   32'(first0), 32'(19));
        checkOutput("narrow alarm",     32'(al2),    32'(1));
        checkOutput("narrow first_cyc", 32'(first2), 32'(15));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
